des_key_schedule_cd: RTL and testbench

Sequential DES key-schedule core that produces the 56-bit C‖D register value for each of the 16 rounds. It accepts a 64-bit key, applies Permuted Choice 1 and performs the per-round rotations, for both encryption and decryption order. It sits directly upstream of the PC2 stage: its round output drives the 56-bit PC2 input, one round per cycle, with a hold input for stalling.

---
 rtl/des_key_schedule_cd.sv | 107 ++++++++++
 tb/tb_des_key_schedule_cd.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule_cd.sv
// rtl/des_key_schedule_cd.sv - DES PC1 + per-round C||D rotation, one round per cycle
module des_key_schedule_cd (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [64:1]  wKeyIn,
  input  logic         wStart,
  input  logic         wDecrypt,
  input  logic         wHold,
  output logic         wReady,
  output logic [56:1]  wCDOut,
  output logic         wRoundValid,
  output logic [4:0]   wRound,
  output logic         wDone
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  state_t       state;
  logic         dec;
  logic [56:1]  pc1_val;
  logic [56:1]  next_cd;
  logic         unused_parity;

  assign unused_parity = ^{wKeyIn[8], wKeyIn[16], wKeyIn[24], wKeyIn[32],
                           wKeyIn[40], wKeyIn[48], wKeyIn[56], wKeyIn[64]};

  // Halves rotate independently, in DES 1-based numbering.
  function automatic logic [56:1] rot(input logic [56:1] v, input logic two, input logic right);
    logic [56:1] r;
    int n;
    int j;
    r = '0;
    n = two ? 2 : 1;
    for (int i = 1; i <= 28; i++) begin
      j = right ? (((i - 1 - n + 28) % 28) + 1) : (((i - 1 + n) % 28) + 1);
      r[i]      = v[j];
      r[28 + i] = v[28 + j];
    end
    return r;
  endfunction

  function automatic logic two_shift(input logic [4:0] r);
    return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
  endfunction

  always_comb begin
    pc1_val = '0;
    for (int i = 0; i < 56; i++) pc1_val[i + 1] = wKeyIn[PC1[i]];
  end

  // Decrypt walks the encrypt schedule backwards: round r undoes shift S[18-r].
  always_comb begin
    next_cd = '0;
    if (dec) next_cd = rot(wCDOut, two_shift(5'd17 - wRound), 1'b1);
    else     next_cd = rot(wCDOut, two_shift(wRound + 5'd1), 1'b0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      dec         <= 1'b0;
      wReady      <= 1'b1;
      wRoundValid <= 1'b0;
      wRound      <= 5'd0;
      wCDOut      <= '0;
      wDone       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wStart) begin
            state       <= RUN;
            dec         <= wDecrypt;
            wReady      <= 1'b0;
            wRoundValid <= 1'b1;
            wRound      <= 5'd1;
            wCDOut      <= wDecrypt ? pc1_val : rot(pc1_val, 1'b0, 1'b0);
            wDone       <= 1'b0;
          end
        end
        RUN: begin
          if (!wHold) begin
            if (wRound == 5'd16) begin
              state       <= IDLE;
              wReady      <= 1'b1;
              wRoundValid <= 1'b0;
              wRound      <= 5'd0;
              wCDOut      <= '0;
              wDone       <= 1'b0;
            end else begin
              wRound <= wRound + 5'd1;
              wCDOut <= next_cd;
              wDone  <= (wRound == 5'd15);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule_cd.sv
// tb/tb_des_key_schedule_cd.sv - scoreboard bench for des_key_schedule_cd
module tb_des_key_schedule_cd;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [64:1]  wKeyIn = '0;
  logic         wStart = 1'b0;
  logic         wDecrypt = 1'b0;
  logic         wHold = 1'b0;
  logic         wReady;
  logic [56:1]  wCDOut;
  logic         wRoundValid;
  logic [4:0]   wRound;
  logic         wDone;

  always #5 clk = ~clk;

  des_key_schedule_cd dut (
    .clk(clk), .rst_n(rst_n), .wKeyIn(wKeyIn), .wStart(wStart),
    .wDecrypt(wDecrypt), .wHold(wHold), .wReady(wReady), .wCDOut(wCDOut),
    .wRoundValid(wRoundValid), .wRound(wRound), .wDone(wDone));

  typedef struct { int rnd; logic [55:0] cd; } exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [55:0] enc_tab [1:16];
  int          nv;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  // Hex constants are written with DES bit 1 leftmost.
  function automatic logic [64:1] from_fips(input logic [63:0] k);
    logic [64:1] r;
    for (int i = 1; i <= 64; i++) r[i] = k[64 - i];
    return r;
  endfunction

  function automatic logic [55:0] to_fips(input logic [56:1] v);
    logic [55:0] r;
    for (int i = 1; i <= 56; i++) r[56 - i] = v[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wRoundValid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_round: got round %0d expected none", wRound);
      end else begin
        check("round_num", 64'(wRound), 64'(sb[0].rnd));
        check("cd_out", 64'(to_fips(wCDOut)), 64'(sb[0].cd));
        check("done_flag", 64'(wDone), 64'(sb[0].rnd == 16));
        if (!wHold) void'(sb.pop_front());
      end
    end
  end

  // kind: 0 = encrypt order, 1 = decrypt order, 2 = all-zero rounds
  task automatic push_exp(input int kind);
    exp_t e;
    for (int r = 1; r <= 16; r++) begin
      e.rnd = r;
      e.cd  = (kind == 0) ? enc_tab[r] : (kind == 1) ? enc_tab[17 - r] : 56'd0;
      sb.push_back(e);
    end
  endtask

  task automatic do_start(input logic [63:0] kf, input logic dec, input int kind);
    check("ready_before_start", 64'(wReady), 64'd1);
    wKeyIn = from_fips(kf);
    wDecrypt = dec;
    wStart = 1'b1;
    push_exp(kind);
    @(posedge clk) #1;
    wStart = 1'b0;
    wDecrypt = 1'b0;
    wKeyIn = from_fips(~kf);
    check("round1_latency", 64'({wRoundValid, wRound}), 64'({1'b1, 5'd1}));
  endtask

  task automatic run_sched(input logic [63:0] kf, input logic dec, input int kind,
                           input int hold_round, input int hold_len, input bit inject,
                           input int stop_round, output int nvalid);
    int hcnt;
    bit done;
    hcnt = 0;
    nvalid = 0;
    done = 0;
    do_start(kf, dec, kind);
    for (int c = 0; c < 60 && !done; c++) begin
      if (wReady) begin
        done = 1;
      end else if (stop_round != 0 && int'(wRound) == stop_round) begin
        return;
      end else begin
        if (wRoundValid) nvalid++;
        if (int'(wRound) == hold_round && hcnt < hold_len) begin
          wHold = 1'b1;
          hcnt++;
        end else begin
          wHold = 1'b0;
        end
        if (inject) begin
          wStart = 1'b1;
          wDecrypt = 1'b1;
          wKeyIn = from_fips(64'hFEDCBA9876543210);
        end
        @(posedge clk) #1;
      end
    end
    wStart = 1'b0;
    wDecrypt = 1'b0;
    wHold = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL run_timeout: got no return to idle expected idle within 60 cycles");
    end
  endtask

  initial begin
    enc_tab[1]  = 56'hE19955FAACCF1E; enc_tab[2]  = 56'hC332ABF5599E3D;
    enc_tab[3]  = 56'h0CCAAFF56678F5; enc_tab[4]  = 56'h332ABFC599E3D5;
    enc_tab[5]  = 56'hCCAAFF06678F55; enc_tab[6]  = 56'h32ABFC399E3D55;
    enc_tab[7]  = 56'hCAAFF0C678F556; enc_tab[8]  = 56'h2ABFC339E3D559;
    enc_tab[9]  = 56'h557F8663C7AAB3; enc_tab[10] = 56'h55FE199F1EAACC;
    enc_tab[11] = 56'h57F8665C7AAB33; enc_tab[12] = 56'h5FE19951EAACCF;
    enc_tab[13] = 56'h7F866557AAB33C; enc_tab[14] = 56'hFE19955EAACCF1;
    enc_tab[15] = 56'hF866557AAB33C7; enc_tab[16] = 56'hF0CCAAF556678F;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready", 64'(wReady), 64'd1);
    check("rst_valid", 64'(wRoundValid), 64'd0);
    check("rst_round", 64'(wRound), 64'd0);
    check("rst_cd", 64'(wCDOut), 64'd0);
    check("rst_done", 64'(wDone), 64'd0);

    wHold = 1'b1;
    repeat (2) @(posedge clk) #1;
    check("idle_hold_ready", 64'({wReady, wRoundValid}), 64'({1'b1, 1'b0}));
    wHold = 1'b0;

    run_sched(KEY, 1'b0, 0, 0, 0, 1'b0, 0, nv);
    check("enc_valid_cycles", 64'(nv), 64'd16);
    run_sched(KEY, 1'b1, 1, 0, 0, 1'b0, 0, nv);
    check("dec_valid_cycles", 64'(nv), 64'd16);
    run_sched(KEY, 1'b0, 0, 5, 3, 1'b0, 0, nv);
    check("hold_valid_cycles", 64'(nv), 64'd19);
    run_sched(KEY, 1'b0, 0, 0, 0, 1'b1, 0, nv);
    check("inject_valid_cycles", 64'(nv), 64'd16);
    run_sched(KEY, 1'b1, 1, 0, 0, 1'b0, 0, nv);
    check("b2b_valid_cycles", 64'(nv), 64'd16);

    run_sched(KEY, 1'b0, 0, 0, 0, 1'b0, 9, nv);
    check("pre_reset_round", 64'(wRound), 64'd9);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk) #1;
    rst_n = 1'b1;
    check("midrun_rst_ready", 64'(wReady), 64'd1);
    check("midrun_rst_valid", 64'(wRoundValid), 64'd0);
    check("midrun_rst_round", 64'(wRound), 64'd0);
    check("midrun_rst_cd", 64'(wCDOut), 64'd0);
    check("midrun_rst_done", 64'(wDone), 64'd0);
    run_sched(KEY, 1'b0, 0, 0, 0, 1'b0, 0, nv);
    check("post_reset_valid_cycles", 64'(nv), 64'd16);

    run_sched(64'h0000000000000000, 1'b0, 2, 0, 0, 1'b0, 0, nv);
    run_sched(64'h0101010101010101, 1'b0, 2, 0, 0, 1'b0, 0, nv);
    run_sched(64'h0101010101010101, 1'b1, 2, 0, 0, 1'b0, 0, nv);

    repeat (2) @(posedge clk) #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
